binary_to_ohc_9_pipe: RTL and testbench

Registered binary-to-one-hot encoder for the modulo-9 RNS channel: the inverse of the 9-bit one-hot-to-binary decoder. It accepts a binary value on a valid/ready interface, reduces it modulo MOD and emits the residue as a MOD-bit one-hot code through a 2-entry output buffer. It sits at the entry of the one-hot modulo-adder datapath. It also reports how many inputs needed reduction.

---
 rtl/binary_to_ohc_9_pipe.sv | 65 ++++++
 tb/tb_binary_to_ohc_9_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_ohc_9_pipe.sv
// binary_to_ohc_9_pipe: reduces a binary input modulo MOD and emits it as a one-hot code
// through a 2-entry output buffer, counting how many inputs needed reduction.
module binary_to_ohc_9_pipe #(
    parameter int MOD   = 9,
    parameter int IN_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MOD-1:0]   out_ohc,
    output logic             out_wrap,
    output logic [CNT_W-1:0] wrap_cnt
);
    logic [1:0]      count;
    logic [MOD-1:0]  head_ohc, tail_ohc, new_ohc;
    logic            head_wrap, tail_wrap, new_wrap;
    logic            push, pop;
    logic [IN_W:0]   ext;
    logic [IN_W-1:0] res;

    always_comb begin
        ext       = {1'b0, in_bin};
        new_wrap  = ext >= (IN_W+1)'(MOD);
        res       = new_wrap ? IN_W'(ext - (IN_W+1)'(MOD)) : in_bin;
        new_ohc   = MOD'(1) << res;
        in_ready  = count != 2'd2;
        out_valid = count != 2'd0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_ohc   = out_valid ? head_ohc : '0;
        out_wrap  = out_valid & head_wrap;
    end

    // The head is written directly when the buffer is (or becomes) empty of older entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_ohc  <= '0;
            head_wrap <= 1'b0;
            tail_ohc  <= '0;
            tail_wrap <= 1'b0;
            wrap_cnt  <= '0;
        end else begin
            count <= push && !pop ? count + 2'd1 : (pop && !push ? count - 2'd1 : count);
            if (push && (count == 2'd0 || pop)) begin
                head_ohc  <= new_ohc;
                head_wrap <= new_wrap;
            end else if (pop) begin
                head_ohc  <= tail_ohc;
                head_wrap <= tail_wrap;
            end
            if (push && count == 2'd1 && !pop) begin
                tail_ohc  <= new_ohc;
                tail_wrap <= new_wrap;
            end
            if (push && new_wrap && !(&wrap_cnt))
                wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_binary_to_ohc_9_pipe.sv
// tb_binary_to_ohc_9_pipe: directed checks of reduction, encoding, buffering and saturation.
module tb_binary_to_ohc_9_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] in_bin = '0;
    logic       in_ready, out_valid, out_wrap;
    logic [8:0] out_ohc;
    logic [7:0] wrap_cnt;
    logic       in_valid2 = 1'b0;
    logic [3:0] in_bin2 = '0;
    logic       in_ready2, out_valid2, out_wrap2;
    logic [8:0] out_ohc2;
    logic [1:0] wrap_cnt2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    binary_to_ohc_9_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_ohc(out_ohc), .out_wrap(out_wrap),
        .wrap_cnt(wrap_cnt)
    );

    binary_to_ohc_9_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(in_bin2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_ohc(out_ohc2), .out_wrap(out_wrap2),
        .wrap_cnt(wrap_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_ohc, out_wrap, in_ready, wrap_cnt} !== {1'b0, 9'h000, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset: valid=%b ohc=%h wrap=%b ready=%b cnt=%0d, want 0 000 0 1 0",
                     out_valid, out_ohc, out_wrap, in_ready, wrap_cnt);
        end
        #10 rst_n = 1'b1;
        step();
    endtask

    task automatic test_sweep();
        logic [8:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_bin = 4'(i);
            step();
            exp = 9'h001 << i;
            checks++;
            if ({out_valid, out_ohc, out_wrap} !== {1'b1, exp, 1'b0}) begin
                errors++;
                $display("FAIL sweep[%0d]: valid=%b ohc=%h wrap=%b, want 1 %h 0", i, out_valid, out_ohc, out_wrap, exp);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, out_ohc, wrap_cnt} !== {1'b0, 9'h000, 8'd0}) begin
            errors++;
            $display("FAIL sweep_drain: valid=%b ohc=%h cnt=%0d, want 0 000 0", out_valid, out_ohc, wrap_cnt);
        end
    endtask

    task automatic test_reduction();
        logic [3:0] ins [3]  = '{4'd9, 4'd12, 4'd15};
        logic [8:0] exps [3] = '{9'h001, 9'h008, 9'h040};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bin = ins[i];
            step();
            checks++;
            if ({out_valid, out_ohc, out_wrap} !== {1'b1, exps[i], 1'b1}) begin
                errors++;
                $display("FAIL reduce[%0d]: valid=%b ohc=%h wrap=%b, want 1 %h 1", ins[i], out_valid, out_ohc, out_wrap, exps[i]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (wrap_cnt !== 8'd3) begin
            errors++;
            $display("FAIL reduce_cnt: got %0d want 3", wrap_cnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_bin = 4'd5;
        step();
        checks++;
        if ({in_ready, out_valid, out_ohc} !== {1'b1, 1'b1, 9'h020}) begin
            errors++;
            $display("FAIL bp_one: ready=%b valid=%b ohc=%h, want 1 1 020", in_ready, out_valid, out_ohc);
        end
        in_bin = 4'd7;
        step();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_ohc} !== {1'b0, 1'b1, 9'h020}) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b ohc=%h, want 0 1 020", in_ready, out_valid, out_ohc);
        end
        step();
        checks++;
        if ({in_ready, out_ohc} !== {1'b0, 9'h020}) begin
            errors++;
            $display("FAIL bp_hold: ready=%b ohc=%h, want 0 020", in_ready, out_ohc);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, out_ohc, out_wrap} !== {1'b1, 1'b1, 9'h080, 1'b0}) begin
            errors++;
            $display("FAIL bp_pop1: ready=%b valid=%b ohc=%h wrap=%b, want 1 1 080 0", in_ready, out_valid, out_ohc, out_wrap);
        end
        step();
        checks++;
        if ({out_valid, out_ohc} !== {1'b0, 9'h000}) begin
            errors++;
            $display("FAIL bp_pop2: valid=%b ohc=%h, want 0 000", out_valid, out_ohc);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_bin = 4'(i);
            step();
            checks++;
            if ({out_valid, out_ohc, in_ready} !== {1'b1, 9'h001 << i, 1'b1}) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b ohc=%h ready=%b, want 1 %h 1", i, out_valid, out_ohc, in_ready, 9'h001 << i);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, wrap_cnt} !== {1'b0, 8'd3}) begin
            errors++;
            $display("FAIL stream_end: valid=%b cnt=%0d, want 0 3", out_valid, wrap_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exps [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        in_valid2 = 1'b1;
        in_bin2 = 4'd10;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({wrap_cnt2, out_ohc2, out_wrap2} !== {exps[i], 9'h002, 1'b1}) begin
                errors++;
                $display("FAIL sat[%0d]: cnt=%0d ohc=%h wrap=%b, want %0d 002 1", i, wrap_cnt2, out_ohc2, out_wrap2, exps[i]);
            end
        end
        in_valid2 = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_bin = 4'd1;
        step();
        in_bin = 4'd11;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_ohc, out_wrap, wrap_cnt, in_ready} !== {1'b0, 9'h000, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ohc=%h wrap=%b cnt=%0d ready=%b, want 0 000 0 0 1",
                     out_valid, out_ohc, out_wrap, wrap_cnt, in_ready);
        end
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_bin = 4'd4;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_ohc, out_wrap} !== {1'b1, 9'h010, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: valid=%b ohc=%h wrap=%b, want 1 010 0", out_valid, out_ohc, out_wrap);
        end
        step();
        checks++;
        if ({out_valid, out_ohc} !== {1'b0, 9'h000}) begin
            errors++;
            $display("FAIL stale: valid=%b ohc=%h, want 0 000", out_valid, out_ohc);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_reduction();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
